// File: rtl/intr_pkg.sv
// Shared constants for the interrogation message path: mode codes and
// field positions inside a {peak, mode} detector message.
package intr_pkg;
   localparam logic [7:0] MODE_A   = 8'h01;
   localparam logic [7:0] MODE_C   = 8'h02;
   localparam int         MODE_LSB = 0;
   localparam int         MODE_W   = 8;
   localparam int         PEAK_LSB = 8;
endpackage

// File: rtl/intr_msg_arbiter_if.sv
// Detector-to-arbiter message bus plus the merged valid/ready output.
// master: detectors + downstream sink; slave: the arbiter.
interface intr_msg_arbiter_if #(
   parameter int NCH = 4,
   parameter int MW  = 24
);
   logic [NCH-1:0]         in_valid;
   logic [NCH*MW-1:0]      in_data;
   logic                   out_valid;
   logic                   out_ready;
   logic [MW-1:0]          out_data;
   logic [$clog2(NCH)-1:0] out_ch;

   modport master (
      output in_valid, in_data, out_ready,
      input  out_valid, out_data, out_ch
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output out_valid, out_data, out_ch
   );
endinterface

// File: rtl/intr_msg_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set req bit after last, wrapping.
// Ports: req, last in; grant_valid, grant_idx out.
module rr_arbiter #(
   parameter int NCH = 4
) (
   input  logic [NCH-1:0]         req,
   input  logic [$clog2(NCH)-1:0] last,
   output logic                   grant_valid,
   output logic [$clog2(NCH)-1:0] grant_idx
);
   localparam int CW = $clog2(NCH);

   int            j;
   logic [CW-1:0] idx;

   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      j           = 0;
      idx         = '0;
      for (int k = 1; k <= NCH; k++) begin
         j = int'(last) + k;
         if (j >= NCH) j = j - NCH;
         idx = CW'(j);
         if (!grant_valid && req[idx]) begin
            grant_valid = 1'b1;
            grant_idx   = idx;
         end
      end
   end
endmodule

// File: rtl/intr_msg_arbiter.sv
// Merges NCH detector strobes into one valid/ready stream with one-deep
// per-channel hold, round-robin grant and dead-time duplicate suppression.
// Ports: clk, rst (sync, high), bus (slave), drop_cnt, dup_cnt, busy.
module intr_msg_arbiter
   import intr_pkg::*;
#(
   parameter int NCH      = 4,
   parameter int WIDTH    = 16,
   parameter int DEAD_CYC = 1500,
   parameter int CNT_W    = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   intr_msg_arbiter_if.slave    bus,
   output logic [CNT_W-1:0]     drop_cnt,
   output logic [CNT_W-1:0]     dup_cnt,
   output logic                 busy
);
   localparam int MW = WIDTH + 8;
   localparam int CW = $clog2(NCH);
   localparam int DW = $clog2(DEAD_CYC + 1);

   localparam logic [0:0] S_EMPTY = 1'b0;
   localparam logic [0:0] S_FULL  = 1'b1;

   logic [0:0]              state_q, state_d;
   logic [NCH-1:0]          pend_q, pend_d;
   logic [NCH-1:0][MW-1:0]  data_q, data_d;
   logic [MW-1:0]           out_data_q, out_data_d;
   logic [CW-1:0]           out_ch_q, out_ch_d;
   logic [CW-1:0]           last_grant_q, last_grant_d;
   logic [DW-1:0]           dead_cnt_q, dead_cnt_d;
   logic [MODE_W-1:0]       last_mode_q, last_mode_d;
   logic [CNT_W-1:0]        drop_cnt_q, drop_cnt_d;
   logic [CNT_W-1:0]        dup_cnt_q, dup_cnt_d;

   logic                    gnt_vld;
   logic [CW-1:0]           gnt_idx;
   logic                    hs, take, dead_act;
   logic [3:0]              ndrop, ndup;
   logic [CNT_W+4:0]        drop_sum, dup_sum;

   rr_arbiter #(.NCH(NCH)) u_rr (
      .req         (pend_q),
      .last        (last_grant_q),
      .grant_valid (gnt_vld),
      .grant_idx   (gnt_idx)
   );

   always_comb begin
      hs           = (state_q == S_FULL) && bus.out_ready;
      // Grant when the output register is free or frees up this cycle.
      take         = gnt_vld && ((state_q == S_EMPTY) || hs);
      dead_act     = (dead_cnt_q != '0);
      state_d      = state_q;
      pend_d       = pend_q;
      data_d       = data_q;
      out_data_d   = out_data_q;
      out_ch_d     = out_ch_q;
      last_grant_d = last_grant_q;
      dead_cnt_d   = dead_cnt_q;
      last_mode_d  = last_mode_q;
      ndrop        = '0;
      ndup         = '0;

      if (take) begin
         state_d      = S_FULL;
         out_data_d   = data_q[gnt_idx];
         out_ch_d     = gnt_idx;
         last_grant_d = gnt_idx;
      end else if (hs) begin
         state_d = S_EMPTY;
      end

      for (int i = 0; i < NCH; i++) begin
         if (take && (gnt_idx == CW'(i))) pend_d[i] = 1'b0;
         if (bus.in_valid[i]) begin
            if (dead_act &&
                bus.in_data[i*MW+MODE_LSB +: MODE_W] == last_mode_q) begin
               ndup = ndup + 4'd1;
            end else if (pend_q[i] && !(take && (gnt_idx == CW'(i)))) begin
               ndrop = ndrop + 4'd1;
            end else begin
               data_d[i] = bus.in_data[i*MW +: MW];
               pend_d[i] = 1'b1;
            end
         end
      end

      if (hs) begin
         dead_cnt_d  = DW'(DEAD_CYC);
         last_mode_d = out_data_q[MODE_LSB +: MODE_W];
      end else if (dead_act) begin
         dead_cnt_d = dead_cnt_q - DW'(1);
      end

      drop_sum   = {5'b0, drop_cnt_q} + {{(CNT_W+1){1'b0}}, ndrop};
      dup_sum    = {5'b0, dup_cnt_q} + {{(CNT_W+1){1'b0}}, ndup};
      drop_cnt_d = (|drop_sum[CNT_W+4:CNT_W]) ? '1 : drop_sum[CNT_W-1:0];
      dup_cnt_d  = (|dup_sum[CNT_W+4:CNT_W]) ? '1 : dup_sum[CNT_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_EMPTY;
         pend_q       <= '0;
         data_q       <= '0;
         out_data_q   <= '0;
         out_ch_q     <= '0;
         last_grant_q <= CW'(NCH - 1);
         dead_cnt_q   <= '0;
         last_mode_q  <= '0;
         drop_cnt_q   <= '0;
         dup_cnt_q    <= '0;
      end else begin
         state_q      <= state_d;
         pend_q       <= pend_d;
         data_q       <= data_d;
         out_data_q   <= out_data_d;
         out_ch_q     <= out_ch_d;
         last_grant_q <= last_grant_d;
         dead_cnt_q   <= dead_cnt_d;
         last_mode_q  <= last_mode_d;
         drop_cnt_q   <= drop_cnt_d;
         dup_cnt_q    <= dup_cnt_d;
      end
   end

   assign bus.out_valid = (state_q == S_FULL);
   assign bus.out_data  = out_data_q;
   assign bus.out_ch    = out_ch_q;
   assign drop_cnt      = drop_cnt_q;
   assign dup_cnt       = dup_cnt_q;
   assign busy          = (|pend_q) || (state_q == S_FULL);
endmodule

// File: tb/tb_intr_msg_arbiter.sv
// Directed bench for intr_msg_arbiter: latency, round-robin order,
// dead-window suppression and boundary, drop, saturation, mid-run reset.
module tb_intr_msg_arbiter;
   import intr_pkg::*;

   localparam int NCH   = 4;
   localparam int WIDTH = 16;
   localparam int MW    = WIDTH + 8;
   localparam int DEAD  = 50;
   localparam int CNTW  = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic [CNTW-1:0] drop_cnt;
   logic [CNTW-1:0] dup_cnt;
   logic            busy;
   int              n_cmp = 0;
   int              n_bad = 0;

   logic [MW-1:0]   bexp [NCH];

   always #5 clk = ~clk;

   intr_msg_arbiter_if #(.NCH(NCH), .MW(MW)) bus ();

   intr_msg_arbiter #(
      .NCH(NCH), .WIDTH(WIDTH), .DEAD_CYC(DEAD), .CNT_W(CNTW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .drop_cnt (drop_cnt),
      .dup_cnt  (dup_cnt),
      .busy     (busy)
   );

   task automatic step(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int ch, input logic [15:0] pk,
                        input logic [7:0] md);
      bus.in_valid[ch]         = 1'b1;
      bus.in_data[ch*MW +: MW] = {pk, md};
   endtask

   task automatic idle();
      bus.in_valid = '0;
   endtask

   task automatic burst();
      drive(0, 16'h1000, 8'h01);
      drive(1, 16'h1111, 8'h02);
      drive(2, 16'h2222, 8'h03);
      drive(3, 16'h3333, 8'h04);
   endtask

   initial begin
      bexp[0] = 24'h100001;
      bexp[1] = 24'h111102;
      bexp[2] = 24'h222203;
      bexp[3] = 24'h333304;
      rst           = 1'b1;
      bus.in_valid  = '0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;
      step(2);
      chk("rst_valid", 32'(bus.out_valid), 0);
      chk("rst_data", 32'(bus.out_data), 0);
      chk("rst_ch", 32'(bus.out_ch), 0);
      chk("rst_drop", 32'(drop_cnt), 0);
      chk("rst_dup", 32'(dup_cnt), 0);
      chk("rst_busy", 32'(busy), 0);
      rst = 1'b0;

      // burst from reset: order 0,1,2,3
      burst();
      step; idle();
      chk("b1_lat", 32'(bus.out_valid), 0);
      for (int k = 0; k < NCH; k++) begin
         step;
         chk("b1_valid", 32'(bus.out_valid), 1);
         chk("b1_ch", 32'(bus.out_ch), 32'(k));
         chk("b1_data", 32'(bus.out_data), 32'(bexp[k]));
      end
      step;
      chk("b1_end_valid", 32'(bus.out_valid), 0);
      chk("b1_end_busy", 32'(busy), 0);
      step(DEAD + 5);

      // single message on ch2
      drive(2, 16'h1234, MODE_A);
      step; idle();
      chk("s_t1_valid", 32'(bus.out_valid), 0);
      chk("s_t1_busy", 32'(busy), 1);
      step;
      chk("s_t2_valid", 32'(bus.out_valid), 1);
      chk("s_t2_ch", 32'(bus.out_ch), 2);
      chk("s_t2_data", 32'(bus.out_data), 32'h123401);
      step;
      chk("s_t3_valid", 32'(bus.out_valid), 0);
      chk("s_t3_busy", 32'(busy), 0);
      step(DEAD + 5);

      // burst after ch2 grant: order 3,0,1,2
      burst();
      step; idle();
      for (int k = 0; k < NCH; k++) begin
         step;
         chk("b2_ch", 32'(bus.out_ch), 32'((3 + k) % NCH));
         chk("b2_data", 32'(bus.out_data), 32'(bexp[(3 + k) % NCH]));
      end
      step;
      chk("b2_end_valid", 32'(bus.out_valid), 0);
      step(DEAD + 5);

      // dead window suppression
      drive(1, 16'h0AAA, MODE_A);
      step; idle();
      step;
      chk("d_first_ch", 32'(bus.out_ch), 1);
      chk("d_first_valid", 32'(bus.out_valid), 1);
      step;
      chk("d_after_valid", 32'(bus.out_valid), 0);
      drive(3, 16'h0BBB, MODE_A);
      step; idle();
      step;
      chk("d_dup1", 32'(dup_cnt), 1);
      chk("d_dup1_busy", 32'(busy), 0);
      chk("d_dup1_valid", 32'(bus.out_valid), 0);
      drive(3, 16'h0C0C, MODE_C);
      step; idle();
      step;
      chk("d_modec_valid", 32'(bus.out_valid), 1);
      chk("d_modec_ch", 32'(bus.out_ch), 3);
      chk("d_modec_data", 32'(bus.out_data), 32'h0C0C02);
      step(DEAD);
      drive(3, 16'h0D0D, MODE_C);
      step; idle();
      chk("d_edge_dup", 32'(dup_cnt), 2);
      chk("d_edge_busy", 32'(busy), 0);
      drive(3, 16'h0E0E, MODE_C);
      step; idle();
      chk("d_past_busy", 32'(busy), 1);
      step;
      chk("d_past_valid", 32'(bus.out_valid), 1);
      chk("d_past_data", 32'(bus.out_data), 32'h0E0E02);

      // hold-register drop with stalled output
      step;
      bus.out_ready = 1'b0;
      drive(1, 16'h0F0F, MODE_A);
      step; idle();
      step;
      chk("h_valid", 32'(bus.out_valid), 1);
      chk("h_ch", 32'(bus.out_ch), 1);
      drive(0, 16'h0101, MODE_A);
      step;
      drive(0, 16'h0202, MODE_A);
      chk("h_stable_data", 32'(bus.out_data), 32'h0F0F01);
      chk("h_drop0", 32'(drop_cnt), 0);
      step; idle();
      chk("h_drop1", 32'(drop_cnt), 1);
      chk("h_stall_ch", 32'(bus.out_ch), 1);
      chk("h_stall_data", 32'(bus.out_data), 32'h0F0F01);
      bus.out_ready = 1'b1;
      step;
      chk("h_next_ch", 32'(bus.out_ch), 0);
      chk("h_next_data", 32'(bus.out_data), 32'h010101);
      step;
      chk("h_end_valid", 32'(bus.out_valid), 0);
      chk("h_end_busy", 32'(busy), 0);
      chk("h_end_drop", 32'(drop_cnt), 1);

      // dup counter saturation, 4 discards per cycle
      for (int c = 0; c < NCH; c++) drive(c, 16'h5A5A, MODE_A);
      step(3);
      chk("sat_14", 32'(dup_cnt), 14);
      step(2);
      chk("sat_15", 32'(dup_cnt), 15);
      idle();
      step;
      chk("sat_hold", 32'(dup_cnt), 15);
      chk("sat_valid", 32'(bus.out_valid), 0);
      chk("sat_busy", 32'(busy), 0);
      step(DEAD + 5);

      // reset while FULL with two pends
      bus.out_ready = 1'b0;
      drive(1, 16'h4444, MODE_A);
      drive(2, 16'h5555, MODE_C);
      drive(3, 16'h6666, MODE_A);
      step; idle();
      step;
      chk("r_pre_valid", 32'(bus.out_valid), 1);
      chk("r_pre_ch", 32'(bus.out_ch), 1);
      rst = 1'b1;
      step;
      rst = 1'b0;
      chk("r_valid", 32'(bus.out_valid), 0);
      chk("r_busy", 32'(busy), 0);
      chk("r_drop", 32'(drop_cnt), 0);
      chk("r_dup", 32'(dup_cnt), 0);
      chk("r_data", 32'(bus.out_data), 0);
      bus.out_ready = 1'b1;
      drive(3, 16'h7777, MODE_A);
      drive(0, 16'h6666, MODE_C);
      step; idle();
      step;
      chk("r_first_ch", 32'(bus.out_ch), 0);
      chk("r_first_data", 32'(bus.out_data), 32'h666602);
      step;
      chk("r_second_ch", 32'(bus.out_ch), 3);
      chk("r_second_data", 32'(bus.out_data), 32'h777701);
      step(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
